// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: turns the built-in FIFO's rd_en / next-cycle dout protocol
// into a valid/ready stream through a 2-entry skid buffer with credit-based reads.
module fifo_stream_drain #(
    parameter int Width      = 18,
    parameter int CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [Width-1:0]      fifo_dout,
    input  logic                  fifo_valid,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [Width-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CountWidth-1:0] word_count,
    output logic                  proto_err
);

    logic [1:0]       occ;
    logic             inflight;
    logic [Width-1:0] mem [2];
    logic             head;
    logic             tail;
    logic             pop;
    logic             capture;
    logic [2:0]       credit;

    assign m_valid = (occ != 2'd0);
    assign m_data  = mem[head];
    assign pop     = m_valid & m_ready;
    assign capture = fifo_valid & inflight;

    // Slots spoken for next cycle: held entries plus the pending read, less the pop.
    assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = rst_n & enable & ~fifo_empty & (credit < 3'd2);

    // Skid storage: captured words land at the tail slot.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[tail] <= fifo_dout;
        end
    end

    // Occupancy, pointers, read tracking, delivery count and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ        <= 2'd0;
            inflight   <= 1'b0;
            head       <= 1'b0;
            tail       <= 1'b0;
            word_count <= '0;
            proto_err  <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (capture) begin
                tail <= ~tail;
            end
            if (pop) begin
                head       <= ~head;
                word_count <= word_count + 1'b1;
            end
            unique case ({capture, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            // Unsolicited data or a missing response both break the read contract.
            if (fifo_valid ^ inflight) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: directed bench with a behavioural non-FWFT FIFO model
// feeding the drain; checks ordering, latency, backpressure, gating, errors, reset.
module tb_fifo_stream_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [17:0] fifo_dout;
    logic        fifo_valid;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [17:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] word_count;
    logic        proto_err;

    logic        n_rd_en;
    logic [17:0] n_data;
    logic        n_valid;
    logic [3:0]  n_count;
    logic        n_err;

    logic [17:0] mem [0:63];
    int          rp;
    int          wp = 0;
    logic        mv;
    logic [17:0] md;
    logic        inj_v = 1'b0;
    logic [17:0] inj_d = '0;

    logic [17:0] rcv [$];
    int          rcv_cyc [$];
    int          cyc = 0;
    int          rd_count = 0;
    int          rd_empty_err = 0;
    int          occ_err = 0;

    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rp == wp);
    assign fifo_valid = mv | inj_v;
    assign fifo_dout  = inj_v ? inj_d : md;

    fifo_stream_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_dout  (fifo_dout),
        .fifo_valid (fifo_valid),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .word_count (word_count),
        .proto_err  (proto_err)
    );

    fifo_stream_drain #(.Width(18), .CountWidth(4)) u_narrow (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_dout  (fifo_dout),
        .fifo_valid (fifo_valid),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (n_rd_en),
        .m_data     (n_data),
        .m_valid    (n_valid),
        .m_ready    (m_ready),
        .word_count (n_count),
        .proto_err  (n_err)
    );

    // Non-FWFT FIFO: data and valid appear the cycle after rd_en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv <= 1'b0;
            md <= '0;
            rp <= 0;
        end else begin
            mv <= fifo_rd_en;
            if (fifo_rd_en) begin
                md <= mem[rp];
                rp <= rp + 1;
            end
        end
    end

    // Stream monitor and running invariants.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (m_valid && m_ready) begin
                rcv.push_back(m_data);
                rcv_cyc.push_back(cyc);
            end
            if (fifo_rd_en) rd_count++;
            if (fifo_rd_en && fifo_empty) rd_empty_err++;
            if (dut.occ > 2'd2) occ_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int n, input logic [17:0] first);
        @(negedge clk);
        rst_n = 1'b0;
        wp = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < n; i++) mem[i] = first + 18'(i);
        wp = n;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input int n, input logic [17:0] first);
        for (int i = 0; i < n; i++) mem[wp + i] = first + 18'(i);
        wp = wp + n;
    endtask

    task automatic wait_rcv(input int target);
        for (int i = 0; i < 400; i++) begin
            if (rcv.size() >= target) break;
            @(negedge clk);
        end
    endtask

    task automatic chk_seq(input string tag, input int base, input int n,
                           input logic [17:0] first);
        chk({tag, "_n"}, rcv.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < rcv.size())
                chk(tag, rcv[base + i], first + 18'(i));
        end
    endtask

    initial begin
        int b;
        int rb;
        int rel;
        logic [7:0] lfsr;

        // Reset state
        rst_n = 1'b0;
        #12;
        chk("rst_valid", m_valid, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_count", word_count, 0);
        chk("rst_err", proto_err, 0);

        // Streaming
        enable = 1'b1;
        m_ready = 1'b1;
        b = rcv.size();
        do_reset(10, 18'h00000);
        rel = cyc;
        #1;
        chk("first_rd_en", fifo_rd_en, 1);
        wait_rcv(b + 10);
        chk_seq("stream", b, 10, 18'h00000);
        if (rcv.size() >= b + 10) begin
            chk("stream_lat", rcv_cyc[b] - rel, 2);
            chk("stream_burst", rcv_cyc[b + 9] - rcv_cyc[b], 9);
        end
        chk("stream_count", word_count, 10);
        chk("stream_err", proto_err, 0);

        // Backpressure
        m_ready = 1'b0;
        b = rcv.size();
        do_reset(20, 18'h00100);
        rb = rd_count;
        repeat (8) @(negedge clk);
        chk("stall_reads", rd_count - rb, 2);
        chk("stall_occ", dut.occ, 2);
        chk("stall_head", m_data, 18'h00100);
        lfsr = 8'h01;
        for (int i = 0; i < 400; i++) begin
            if (rcv.size() >= b + 20) break;
            m_ready = lfsr[0];
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            @(negedge clk);
        end
        m_ready = 1'b1;
        chk_seq("bp", b, 20, 18'h00100);
        chk("bp_count", word_count, 20);
        chk("bp_rd_empty", rd_empty_err, 0);
        chk("bp_occ_max", occ_err, 0);

        // Enable gating
        m_ready = 1'b0;
        b = rcv.size();
        do_reset(5, 18'h00050);
        rb = rd_count;
        @(negedge clk);
        enable = 1'b0;
        #1;
        chk("gate_rd_off", fifo_rd_en, 0);
        repeat (5) @(negedge clk);
        chk("gate_reads", rd_count - rb, 1);
        chk("gate_occ1", dut.occ, 1);
        chk("gate_head", m_data, 18'h00050);
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_seq("gate_word", b, 1, 18'h00050);
        chk("gate_occ0", dut.occ, 0);
        chk("gate_reads2", rd_count - rb, 1);
        enable = 1'b1;
        wait_rcv(b + 5);
        chk_seq("gate_rest", b, 5, 18'h00050);

        // Protocol error
        b = rcv.size();
        do_reset(0, 18'h0);
        @(negedge clk);
        inj_d = 18'h3FFFF;
        inj_v = 1'b1;
        @(negedge clk);
        inj_v = 1'b0;
        chk("perr_set", proto_err, 1);
        chk("perr_nodata", m_valid, 0);
        repeat (3) @(negedge clk);
        chk("perr_sticky", proto_err, 1);
        load(3, 18'h00020);
        wait_rcv(b + 3);
        chk_seq("perr_after", b, 3, 18'h00020);
        chk("perr_hold", proto_err, 1);

        // Counter wrap
        b = rcv.size();
        do_reset(17, 18'h00200);
        wait_rcv(b + 17);
        chk_seq("wrap", b, 17, 18'h00200);
        chk("wrap_wide", word_count, 17);
        chk("wrap_narrow", n_count, 1);

        // Async reset mid-stream
        b = rcv.size();
        do_reset(10, 18'h00300);
        wait_rcv(b + 3);
        m_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("ar_occ", dut.occ, 2);
        chk("ar_count", word_count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", m_valid, 0);
        chk("ar_rd_en", fifo_rd_en, 0);
        chk("ar_wc", word_count, 0);
        m_ready = 1'b1;
        b = rcv.size();
        do_reset(4, 18'h00400);
        wait_rcv(b + 4);
        chk_seq("ar_restart", b, 4, 18'h00400);
        chk("ar_err", proto_err, 0);
        chk("ar_rd_empty", rd_empty_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
